// File: rtl/nibble_serial_tx_pkg.sv
// Shared definitions for the nibble serial link: frame levels, sizes and the
// FSM state encoding used by both the transmitter and the receiver.
package nibble_serial_tx_pkg;

  localparam int unsigned DATA_BITS  = 4;
  localparam int unsigned DATA_IDX_W = 2;
  localparam logic        START_LVL  = 1'b0;
  localparam logic        STOP_LVL   = 1'b1;

  typedef logic [DATA_BITS-1:0] nibble_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Small nibble FIFO with occupancy count and a registered ready flag.
module nibble_fifo
  import nibble_serial_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  nibble_t                      wdata,
  output nibble_t                      rdata_c,
  output logic                         empty_c,
  output logic                         ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  nibble_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full_c;
  logic             wr_en;
  logic             rd_en;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign rdata_c = mem[rd_ptr];
  assign wr_en   = push && !full_c;
  assign rd_en   = pop && !empty_c;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Ready ignores a same-cycle pop, so it recovers one edge after space frees up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      ready <= !(full_c || (wr_en && (count == CNT_W'(DEPTH - 1))));
    end
  end

endmodule

// File: rtl/nibble_serial_tx.sv
// Buffers 4-bit codes and serialises each as start, 4 data bits LSB first,
// stop, with optional idle gap, onto a single idle-high line.
module nibble_serial_tx
  import nibble_serial_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned GAP_BITS   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        i_data,
  input  logic                              i_valid,
  output logic                              o_ready,
  output logic                              o_TX_Bit,
  output logic                              o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);

  localparam int unsigned BC_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IDX_W    = $clog2(max_u(DATA_BITS, GAP_BITS));
  localparam int unsigned GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  tx_state_e        state, state_n;
  logic [BC_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  nibble_t          shift, shift_n;
  nibble_t          rdata_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;
  logic             bit_done_c;
  logic             frame_end_c;
  logic             tx_n;

  assign push_c     = i_valid && o_ready;
  assign bit_done_c = (cnt == BC_W'(BIT_CYCLES - 1));

  nibble_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (i_data),
    .rdata_c (rdata_c),
    .empty_c (empty_c),
    .ready   (o_ready),
    .count   (o_fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      o_TX_Bit <= STOP_LVL;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      o_TX_Bit <= tx_n;
      o_busy   <= (state_n != ST_IDLE);
    end
  end

  // Next state; frame_end_c funnels IDLE, STOP and GAP into one pop-or-idle exit.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shift_n     = shift;
    pop_c       = 1'b0;
    frame_end_c = 1'b0;
    tx_n        = STOP_LVL;

    if (state != ST_IDLE) cnt_n = bit_done_c ? '0 : cnt + BC_W'(1);

    case (state)
      ST_IDLE:  frame_end_c = 1'b1;
      ST_START: begin
        if (bit_done_c) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done_c) begin
          if (idx == IDX_W'(DATA_BITS - 1)) state_n = ST_STOP;
          else                              idx_n   = idx + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_done_c) begin
          if (GAP_BITS > 0) begin
            state_n = ST_GAP;
            idx_n   = '0;
          end else begin
            frame_end_c = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (bit_done_c) begin
          if (idx == IDX_W'(GAP_LAST)) frame_end_c = 1'b1;
          else                         idx_n       = idx + IDX_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (frame_end_c) begin
      if (!empty_c) begin
        pop_c   = 1'b1;
        shift_n = rdata_c;
        state_n = ST_START;
        cnt_n   = '0;
      end else begin
        state_n = ST_IDLE;
      end
    end

    case (state_n)
      ST_START: tx_n = START_LVL;
      ST_DATA:  tx_n = shift_n[idx_n[DATA_IDX_W-1:0]];
      default:  tx_n = STOP_LVL;
    endcase
  end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Bench for nibble_serial_tx: queue-based line model for two configurations
// plus literal frame checks on recorded line histories.
module tb_nibble_serial_tx;

  localparam int DEPTH = 4;

  typedef bit bitq_t[$];
  typedef logic [3:0] nibq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       va = 1'b0, vb = 1'b0;
  logic [3:0] da = 4'h0, db = 4'h0;
  logic       a_rdy, a_tx, a_busy, b_rdy, b_tx, b_busy;
  logic [2:0] a_cnt, b_cnt;

  nibble_serial_tx #(.FIFO_DEPTH(4), .BIT_CYCLES(1), .GAP_BITS(0)) dut_a (
    .clk(clk), .rst(rst), .i_data(da), .i_valid(va), .o_ready(a_rdy),
    .o_TX_Bit(a_tx), .o_busy(a_busy), .o_fifo_count(a_cnt)
  );

  nibble_serial_tx #(.FIFO_DEPTH(4), .BIT_CYCLES(3), .GAP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .i_data(db), .i_valid(vb), .o_ready(b_rdy),
    .o_TX_Bit(b_tx), .o_busy(b_busy), .o_fifo_count(b_cnt)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  bitq_t lq_a, lq_b, hist_a, hist_b;
  nibq_t fq_a, fq_b;
  bit    mr_a = 1'b1, mr_b = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the abstract model: the line queue holds every remaining bit
  // time of the frame in flight; a new frame is fetched once it has drained.
  task automatic model_step(ref bitq_t lq, ref nibq_t fq, output bit rdy,
                            input bit push, input logic [3:0] d, input int bc, input int gap);
    int         c0;
    logic [3:0] nib;
    bit         lvl;
    c0 = fq.size();
    if (lq.size() > 0) void'(lq.pop_front());
    if (lq.size() == 0 && fq.size() > 0) begin
      nib = fq.pop_front();
      for (int b = 0; b < 6; b++) begin
        if (b == 0)      lvl = 1'b0;
        else if (b == 5) lvl = 1'b1;
        else             lvl = nib[b-1];
        repeat (bc) lq.push_back(lvl);
      end
      repeat (gap * bc) lq.push_back(1'b1);
    end
    if (push) fq.push_back(d);
    rdy = (c0 + int'(push)) < DEPTH;
  endtask

  function automatic bit exp_line(input bitq_t lq);
    return (lq.size() > 0) ? lq[0] : 1'b1;
  endfunction

  task automatic compare_all();
    check("a_line",  32'(a_tx),   32'(exp_line(lq_a)));
    check("a_busy",  32'(a_busy), 32'(lq_a.size() > 0));
    check("a_count", 32'(a_cnt),  32'(fq_a.size()));
    check("a_ready", 32'(a_rdy),  32'(mr_a));
    check("b_line",  32'(b_tx),   32'(exp_line(lq_b)));
    check("b_busy",  32'(b_busy), 32'(lq_b.size() > 0));
    check("b_count", 32'(b_cnt),  32'(fq_b.size()));
    check("b_ready", 32'(b_rdy),  32'(mr_b));
  endtask

  task automatic tick();
    bit pa, pb;
    pa = va && mr_a;
    pb = vb && mr_b;
    @(posedge clk);
    if (!rst) begin
      model_step(lq_a, fq_a, mr_a, pa, da, 1, 0);
      model_step(lq_b, fq_b, mr_b, pb, db, 3, 2);
    end
    @(negedge clk);
    compare_all();
    hist_a.push_back(a_tx);
    hist_b.push_back(b_tx);
  endtask

  function automatic logic [5:0] pick6(input bitq_t h, input int start, input int step);
    logic [5:0] v = '0;
    for (int k = 0; k < 6; k++) v = {v[4:0], h[start + k*step]};
    return v;
  endfunction

  // Recover nibbles from a 1-cycle-per-bit line history.
  task automatic decode(input bitq_t h, output logic [23:0] rb, output int frames, output int gaps);
    int i = 0;
    int prev_end = -1;
    rb = '0; frames = 0; gaps = 0;
    while (i + 5 < h.size()) begin
      if (h[i] == 1'b0) begin
        rb = {rb[19:0], h[i+4], h[i+3], h[i+2], h[i+1]};
        if (prev_end >= 0) gaps += i - prev_end;
        prev_end = i + 6;
        frames++;
        i += 6;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    logic [23:0] rb;
    int          fr, gp, first_zero;
    bit          acc;
    int          guard;

    repeat (3) @(negedge clk);
    check("rst_a_line",  32'(a_tx),  32'd1);
    check("rst_a_ready", 32'(a_rdy), 32'd1);
    check("rst_a_busy",  32'(a_busy), 32'd0);
    check("rst_a_count", 32'(a_cnt), 32'd0);
    check("rst_b_line",  32'(b_tx),  32'd1);
    check("rst_b_busy",  32'(b_busy), 32'd0);
    rst = 1'b0;
    repeat (20) tick();

    // Single 4'hA on A; two 4'h5 on the slow, gapped B.
    hist_a.delete(); hist_b.delete();
    va = 1'b1; da = 4'hA; vb = 1'b1; db = 4'h5;
    tick();
    va = 1'b0; da = 4'($urandom);
    tick();
    vb = 1'b0; db = 4'($urandom);
    repeat (48) tick();
    check("a_frame_A",     32'(pick6(hist_a, 1, 1)), 32'(6'b001011));
    check("a_idle_after",  32'(pick6(hist_a, 7, 1)), 32'(6'b111111));
    check("b_start_hold",  32'({hist_b[1], hist_b[2], hist_b[3]}), 32'(3'b000));
    check("b_d0_hold",     32'({hist_b[4], hist_b[5], hist_b[6]}), 32'(3'b111));
    check("b_frame1",      32'(pick6(hist_b, 1, 3)), 32'(6'b010101));
    first_zero = -1;
    for (int i = 19; i < hist_b.size(); i++)
      if (first_zero < 0 && hist_b[i] == 1'b0) first_zero = i;
    check("b_gap_start", 32'(first_zero), 32'd25);
    check("b_frame2",    32'(pick6(hist_b, 25, 3)), 32'(6'b010101));

    // Back-to-back 1..6 decoded as a downstream receiver would.
    hist_a.delete();
    for (int v = 1; v <= 6; v++) begin
      va = 1'b1; da = 4'(v);
      guard = 0;
      do begin
        acc = a_rdy;
        tick();
        guard++;
      end while (!acc && guard < 50);
      check("push_accept", 32'(acc), 32'd1);
    end
    va = 1'b0;
    repeat (50) tick();
    decode(hist_a, rb, fr, gp);
    check("rx_buffer", 32'(rb), 32'h123456);
    check("rx_frames", 32'(fr), 32'd6);
    check("rx_gaps",   32'(gp), 32'd0);

    // Hold valid high: fill to 4, ready recovers one edge after the pop.
    va = 1'b1;
    repeat (5) begin da = 4'($urandom); tick(); end
    check("full_count", 32'(a_cnt), 32'd4);
    check("full_ready", 32'(a_rdy), 32'd0);
    repeat (3) begin da = 4'($urandom); tick(); end
    check("pop_count",  32'(a_cnt), 32'd3);
    check("pop_ready",  32'(a_rdy), 32'd0);
    tick();
    check("rise_ready", 32'(a_rdy), 32'd1);
    check("rise_count", 32'(a_cnt), 32'd3);
    va = 1'b0;
    repeat (40) tick();

    // Reset in the middle of a 4'hF frame with one more nibble queued.
    va = 1'b1; da = 4'hF; tick();
    da = 4'h7; tick();
    va = 1'b0;
    repeat (2) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_line",  32'(a_tx),   32'd1);
    check("midrst_count", 32'(a_cnt),  32'd0);
    check("midrst_busy",  32'(a_busy), 32'd0);
    check("midrst_ready", 32'(a_rdy),  32'd1);
    lq_a.delete(); fq_a.delete(); mr_a = 1'b1;
    lq_b.delete(); fq_b.delete(); mr_b = 1'b1;
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    hist_a.delete();
    va = 1'b1; da = 4'h3; tick();
    va = 1'b0;
    repeat (12) tick();
    check("post_rst_frame", 32'(pick6(hist_a, 1, 1)), 32'(6'b011001));
    check("post_rst_idle",  32'(pick6(hist_a, 7, 1)), 32'(6'b111111));

    // Randomised traffic on both configurations.
    repeat (400) begin
      va = ($urandom_range(0, 3) != 0);
      da = 4'($urandom);
      vb = ($urandom_range(0, 7) == 0);
      db = 4'($urandom);
      tick();
    end
    va = 1'b0; vb = 1'b0;
    repeat (200) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
